// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit that owns the HI/LO registers.
// Start ops (MULT/MULTU/DIV/DIVU) latch their operands and hold BusyE for a
// fixed number of cycles. The result is committed to HI/LO on the last busy
// cycle. MTHI/MTLO are single-cycle writes, and MFHI/MFLO read HI/LO combinationally.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MdOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        HiLoSelE,
  output logic        BusyE,
  output logic [31:0] MdOutE
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] opA_q, opA_d;
  logic [31:0] opB_q, opB_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic               start;
  logic signed [63:0] prodS;
  logic        [63:0] prodU;
  logic               divByZero;
  logic               divOverflow;
  logic        [31:0] safeDivisorS;
  logic        [31:0] safeDivisorU;
  logic signed [31:0] quotS, remS;
  logic        [31:0] quotU, remU;
  logic        [31:0] resHi, resLo;

  // A start is a multiply/divide op seen while idle. Reset suppresses it so that a start during reset never begins.
  assign start = (state_q == IDLE) && !reset && (MdOpE >= OP_MULT) && (MdOpE <= OP_DIVU);

  assign BusyE  = (state_q == BUSY) || start;
  assign MdOutE = HiLoSelE ? hi_q : lo_q;

  // Compute the result from the latched operands. Divisors of zero and the
  // signed INT_MIN / -1 case are replaced by 1 so that the divider never sees an undefined case.
  always_comb begin
    prodS        = $signed(opA_q) * $signed(opB_q);
    prodU        = {32'd0, opA_q} * {32'd0, opB_q};
    divByZero    = (opB_q == 32'd0);
    divOverflow  = (opA_q == 32'h8000_0000) && (opB_q == 32'hFFFF_FFFF);
    safeDivisorS = (divByZero || divOverflow) ? 32'd1 : opB_q;
    safeDivisorU = divByZero ? 32'd1 : opB_q;
    quotS        = $signed(opA_q) / $signed(safeDivisorS);
    remS         = $signed(opA_q) % $signed(safeDivisorS);
    quotU        = opA_q / safeDivisorU;
    remU         = opA_q % safeDivisorU;
    resHi        = hi_q;
    resLo        = lo_q;
    case (op_q)
      OP_MULT: begin
        resHi = prodS[63:32];
        resLo = prodS[31:0];
      end
      OP_MULTU: begin
        resHi = prodU[63:32];
        resLo = prodU[31:0];
      end
      OP_DIV: begin
        if (divByZero) begin
          resHi = opA_q;
          resLo = 32'hFFFF_FFFF;
        end else if (divOverflow) begin
          resHi = 32'd0;
          resLo = 32'h8000_0000;
        end else begin
          resHi = remS;
          resLo = quotS;
        end
      end
      OP_DIVU: begin
        if (divByZero) begin
          resHi = opA_q;
          resLo = 32'hFFFF_FFFF;
        end else begin
          resHi = remU;
          resLo = quotU;
        end
      end
      default: begin
        resHi = hi_q;
        resLo = lo_q;
      end
    endcase
  end

  // Next-state logic: start or MTHI/MTLO while idle, count down and commit while busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = MdOpE;
          opA_d   = SrcAE;
          opB_d   = SrcBE;
          cnt_d   = (MdOpE <= OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          state_d = BUSY;
        end else if (MdOpE == OP_MTHI) begin
          hi_d = SrcAE;
        end else if (MdOpE == OP_MTLO) begin
          lo_d = SrcAE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = resHi;
          lo_d    = resLo;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand latches and HI/LO registers. Reset clears everything, which also aborts any operation that is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      opA_q   <= 32'd0;
      opB_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit for the 5-stage MIPS pipeline, sitting in the EX stage beside the ALU.
- Owns the architectural HI/LO registers and sequences MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations.
- Executes MTHI/MTLO and serves MFHI/MFLO reads.
- Drives BusyE, which the hazard unit combines with IsMdD to stall any md-class instruction in Decode until the unit is free.

Parameters:
- MULT_CYCLES, 5, cycles the busy state is held for MULT/MULTU (1..15).
- DIV_CYCLES, 10, cycles the busy state is held for DIV/DIVU (1..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MdOpE  input  3  EX-stage op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- SrcAE  input  32  forwarded rs value; multiplicand, dividend, or MTHI/MTLO data.
- SrcBE  input  32  forwarded rt value; multiplier or divisor.
- HiLoSelE  input  1  read select: 1 = HI, 0 = LO.
- BusyE  output  1  unit occupied; to the hazard unit.
- MdOutE  output  32  HI or LO per HiLoSelE, for MFHI/MFLO.

Behaviour:
- Reset (synchronous):
  - HI = 0, LO = 0, state = IDLE, counter = 0, operand latches cleared.
  - BusyE = 0 and MdOutE = 0 in the cycle after reset is sampled.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - MdOpE in 1..4 (a "start") latches SrcAE, SrcBE and the op.
  - Counter loads MULT_CYCLES or DIV_CYCLES; state goes to BUSY.
- BUSY:
  - Counter decrements every cycle.
  - On the edge where the counter is 1, the latched result is written to HI/LO and the state returns to IDLE.
- BusyE = (state == BUSY) | (state == IDLE & start).
  - BusyE is combinational in the start cycle, so the md instruction directly behind is stalled.
- Timing for a start in cycle t:
  - BusyE is high in cycles t .. t+N (N = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO are visible on MdOutE from cycle t+N+1, the same cycle BusyE falls.
- Arithmetic, computed from the latched operands:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Division by zero (DIV or DIVU): HI = dividend, LO = 0xFFFFFFFF.
  - DIV 0x80000000 / -1: LO = 0x80000000, HI = 0.
- MTHI/MTLO:
  - Executed only in IDLE.
  - HI (or LO) = SrcAE at the end of the cycle.
  - Single-cycle; BusyE stays 0.
  - Readable via MdOutE the next cycle.
- MdOutE is combinational from the architectural HI/LO only.
  - In-flight results are never exposed; there is no bypass.
- Ops 1..6 arriving while BUSY are ignored: HI/LO, counter and latches are unchanged.
  - The hazard unit guarantees this does not occur. A violation is a verification error, not a functional mode.
- Op 0 or 7: no effect.
- Reset in BUSY aborts the operation: HI/LO = 0, state = IDLE, BusyE = 0 the next cycle, and no late write occurs.
- Reset and start in the same cycle: reset wins, so the op is not started.

Test Plan:
- MULT, SrcAE = 0xFFFFFFFD (-3), SrcBE = 5 -> BusyE high 6 cycles (t..t+5); from t+6 HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 2 -> HI = 0x00000001, LO = 0xFFFFFFFE; during BUSY, MdOutE holds the old HI/LO.
- DIV -7 / 2 -> after 11 busy cycles LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 0 -> HI = 7, LO = 0xFFFFFFFF.
- MTLO 0x12345678 then MFLO (HiLoSelE = 0) next cycle -> MdOutE = 0x12345678, BusyE never asserted. MTHI issued during BUSY -> HI unchanged.
- DIV started, reset asserted at t+4 -> from t+5 BusyE = 0, HI = LO = 0, and HI/LO remain 0 through t+12.
- Back-to-back MULT: second MULT held at MdOpE until BusyE falls -> it starts exactly at t+6; its result is visible at t+12 and the first result is not corrupted.
